// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the arithmetic-unit scheduler.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] FUN_ADD = 2'b00;
    localparam logic [1:0] FUN_SUB = 2'b01;
    localparam logic [1:0] FUN_MUL = 2'b10;
    localparam logic [1:0] FUN_DIV = 2'b11;

    localparam int CNT_W = 4;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module rr_arbiter_2 (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_grant_i,
    output logic grant_o,
    output logic grant_valid_o
);

    always_comb begin
        grant_valid_o = valid0_i | valid1_i;
        if (valid0_i && valid1_i) begin
            grant_o = ~last_grant_i;
        end else begin
            grant_o = valid1_i;
        end
    end

endmodule

// File: rtl/alu_arith_scheduler.sv
// Shares one arithmetic unit between two requesters with round-robin arbitration and a WAIT timeout.
// Optional macro DIV0_GUARD_EN: divide-by-zero is answered with an error without issuing to the unit.
module alu_arith_scheduler
    import alu_sched_pkg::*;
#(
    parameter int A_WIDTH        = 8,
    parameter int B_WIDTH        = 8,
    parameter int OUT_WIDTH      = 8,
    parameter int ALU_FUN_WIDTH  = 2,
    parameter int TIMEOUT_CYCLES = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REQ0_VALID,
    output logic                     REQ0_READY,
    input  logic [A_WIDTH-1:0]       REQ0_A,
    input  logic [B_WIDTH-1:0]       REQ0_B,
    input  logic [ALU_FUN_WIDTH-1:0] REQ0_FUN,
    input  logic                     REQ1_VALID,
    output logic                     REQ1_READY,
    input  logic [A_WIDTH-1:0]       REQ1_A,
    input  logic [B_WIDTH-1:0]       REQ1_B,
    input  logic [ALU_FUN_WIDTH-1:0] REQ1_FUN,
    output logic [A_WIDTH-1:0]       ALU_A,
    output logic [B_WIDTH-1:0]       ALU_B,
    output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
    output logic                     ALU_EN,
    input  logic [OUT_WIDTH-1:0]     ALU_OUT,
    input  logic                     ALU_OUT_VALID,
    output logic                     RSP_VALID,
    input  logic                     RSP_READY,
    output logic [OUT_WIDTH-1:0]     RSP_DATA,
    output logic                     RSP_ID,
    output logic                     RSP_ERR
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                   state_q, state_d;
    logic                     last_grant_q, last_grant_d;
    logic [A_WIDTH-1:0]       a_q, a_d;
    logic [B_WIDTH-1:0]       b_q, b_d;
    logic [ALU_FUN_WIDTH-1:0] fun_q, fun_d;
    logic                     id_q, id_d;
    logic [OUT_WIDTH-1:0]     data_q, data_d;
    logic                     err_q, err_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     grant, grant_valid;

    rr_arbiter_2 u_arb (
        .valid0_i      (REQ0_VALID),
        .valid1_i      (REQ1_VALID),
        .last_grant_i  (last_grant_q),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        fun_d        = fun_q;
        id_d         = id_q;
        data_d       = data_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        ALU_EN       = 1'b0;
        REQ0_READY   = 1'b0;
        REQ1_READY   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    REQ0_READY   = ~grant;
                    REQ1_READY   = grant;
                    a_d          = grant ? REQ1_A   : REQ0_A;
                    b_d          = grant ? REQ1_B   : REQ0_B;
                    fun_d        = grant ? REQ1_FUN : REQ0_FUN;
                    id_d         = grant;
                    last_grant_d = grant;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = '0;
`ifdef DIV0_GUARD_EN
                if (fun_q == ALU_FUN_WIDTH'(FUN_DIV) && b_q == '0) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    ALU_EN  = 1'b1;
                    state_d = S_WAIT;
                end
`else
                ALU_EN  = 1'b1;
                state_d = S_WAIT;
`endif
            end
            S_WAIT: begin
                if (ALU_OUT_VALID) begin
                    data_d  = ALU_OUT;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    // Unit never answered: release the requester with an error.
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (RSP_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            fun_q        <= '0;
            id_q         <= 1'b0;
            data_q       <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            fun_q        <= fun_d;
            id_q         <= id_d;
            data_q       <= data_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ALU_A     = a_q;
    assign ALU_B     = b_q;
    assign ALU_FUN   = fun_q;
    assign RSP_VALID = (state_q == S_RESP);
    assign RSP_DATA  = data_q;
    assign RSP_ID    = id_q;
    assign RSP_ERR   = err_q;

endmodule

// File: tb/tb_alu_arith_scheduler.sv
// Self-checking bench for alu_arith_scheduler with an attached registered arithmetic-unit model.
module tb_alu_arith_scheduler;
    import alu_sched_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
    logic       REQ0_READY, REQ1_READY;
    logic [7:0] REQ0_A = '0, REQ0_B = '0, REQ1_A = '0, REQ1_B = '0;
    logic [1:0] REQ0_FUN = '0, REQ1_FUN = '0;
    logic [7:0] ALU_A, ALU_B;
    logic [1:0] ALU_FUN;
    logic       ALU_EN;
    logic [7:0] ALU_OUT = '0;
    logic       ALU_OUT_VALID = 1'b0;
    logic       RSP_VALID;
    logic       RSP_READY = 1'b1;
    logic [7:0] RSP_DATA;
    logic       RSP_ID, RSP_ERR;

    int checks = 0, failures = 0, cyc = 0, en_cnt = 0, en_cyc = -1, last_g = 1;
    bit suppress = 1'b0, inject = 1'b0;
    bit         pend [2];
    logic [7:0] opa [2], opb [2];
    logic [1:0] opf [2];

    typedef struct {
        int         rid;
        logic [7:0] a, b;
        logic [1:0] f;
        logic [7:0] exp_d;
    } vec_t;
    vec_t tbl [8];

    always #5 CLK = ~CLK;

    alu_arith_scheduler #(
        .A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(8), .ALU_FUN_WIDTH(2), .TIMEOUT_CYCLES(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_FUN(REQ0_FUN),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_FUN(REQ1_FUN),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ID(RSP_ID), .RSP_ERR(RSP_ERR)
    );

    // Arithmetic unit: result and OUT_VALID registered one cycle after Arith_Enable.
    always @(posedge CLK) begin
        ALU_OUT_VALID <= (ALU_EN && !suppress) || inject;
        if (inject) begin
            ALU_OUT <= 8'hAA;
        end else if (ALU_EN) begin
            case (ALU_FUN)
                2'b00:   ALU_OUT <= ALU_A + ALU_B;
                2'b01:   ALU_OUT <= ALU_A - ALU_B;
                2'b10:   ALU_OUT <= 8'((16'(ALU_A) * 16'(ALU_B)) & 16'hFF);
                default: ALU_OUT <= (ALU_B == 8'd0) ? 8'hFF : ALU_A / ALU_B;
            endcase
        end
    end

    always @(negedge CLK) begin
        if (ALU_EN === 1'b1) begin
            en_cnt++;
            en_cyc = cyc;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void ref_res(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f,
                                    output logic [7:0] d, output logic e);
        int x;
        e = 1'b0;
        case (f)
            2'd0:    x = int'(a) + int'(b);
            2'd1:    x = int'(a) - int'(b) + 256;
            2'd2:    x = int'(a) * int'(b);
            default: x = (b == 8'd0) ? 255 : int'(a) / int'(b);
        endcase
`ifdef DIV0_GUARD_EN
        if (f == 2'd3 && b == 8'd0) begin
            x = 0;
            e = 1'b1;
        end
`endif
        d = 8'(x % 256);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic drive_req(input int rid, input bit v, input logic [7:0] a, input logic [7:0] b,
                             input logic [1:0] f);
        if (rid == 0) begin
            REQ0_VALID = v; REQ0_A = a; REQ0_B = b; REQ0_FUN = f;
        end else begin
            REQ1_VALID = v; REQ1_A = a; REQ1_B = b; REQ1_FUN = f;
        end
    endtask

    task automatic wait_ready(input int rid, output int acc);
        acc = -1;
        for (int k = 0; k < 20 && acc < 0; k++) begin
            @(negedge CLK);
            if ((rid == 0 && REQ0_READY === 1'b1) || (rid == 1 && REQ1_READY === 1'b1)) acc = cyc;
            tick();
        end
        if (acc < 0) begin
            checks++; failures++;
            $display("FAIL accept_timeout: requester %0d never saw READY", rid);
        end
    endtask

    task automatic wait_rsp(output int rc);
        rc = -1;
        for (int k = 0; k < 40 && rc < 0; k++) begin
            @(negedge CLK);
            if (RSP_VALID === 1'b1) rc = cyc;
            else tick();
        end
        if (rc < 0) begin
            checks++; failures++;
            $display("FAIL rsp_timeout: RSP_VALID never asserted");
        end
    endtask

    task automatic do_op(input int rid, input logic [7:0] a, input logic [7:0] b, input logic [1:0] f,
                         output logic [7:0] d, output logic id, output logic e,
                         output int lat_en, output int lat_rsp);
        int acc, rc;
        RSP_READY = 1'b1;
        en_cnt = 0;
        en_cyc = -1;
        drive_req(rid, 1'b1, a, b, f);
        wait_ready(rid, acc);
        drive_req(rid, 1'b0, a, b, f);
        last_g = rid;
        wait_rsp(rc);
        d = RSP_DATA; id = RSP_ID; e = RSP_ERR;
        lat_en  = (en_cyc < 0 || acc < 0) ? -1 : en_cyc - acc;
        lat_rsp = (rc < 0 || acc < 0) ? -1 : rc - acc;
        if (rc >= 0) tick();
    endtask

    task automatic serve_one(input bit bp);
        int w;
        logic [7:0] exp_d, d0;
        logic exp_e, id0, e0;
        bit busy_rdy, seen, done, stab_bad;
        drive_req(0, pend[0], opa[0], opb[0], opf[0]);
        drive_req(1, pend[1], opa[1], opb[1], opf[1]);
        w = (pend[0] && pend[1]) ? 1 - last_g : (pend[1] ? 1 : 0);
        @(negedge CLK);
        chk("arb_ready", {30'd0, REQ1_READY, REQ0_READY}, (w == 1) ? 32'd2 : 32'd1);
        tick();
        pend[w] = 1'b0;
        drive_req(w, 1'b0, opa[w], opb[w], opf[w]);
        last_g = w;
        ref_res(opa[w], opb[w], opf[w], exp_d, exp_e);
        busy_rdy = 0; seen = 0; done = 0; stab_bad = 0;
        d0 = '0; id0 = 1'b0; e0 = 1'b0;
        RSP_READY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge CLK);
            if (REQ0_READY === 1'b1 || REQ1_READY === 1'b1) busy_rdy = 1;
            if (RSP_VALID === 1'b1 && !seen) begin
                seen = 1; d0 = RSP_DATA; id0 = RSP_ID; e0 = RSP_ERR;
            end
            if (RSP_VALID === 1'b1 && (RSP_DATA !== d0 || RSP_ID !== id0 || RSP_ERR !== e0)) stab_bad = 1;
            if (RSP_VALID === 1'b1 && RSP_READY) done = 1;
            tick();
            RSP_READY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        RSP_READY = 1'b1;
        chk("rr_done", 32'(done), 32'd1);
        chk("rr_data", 32'(d0), 32'(exp_d));
        chk("rr_id", 32'(id0), 32'(w));
        chk("rr_err", 32'(e0), 32'(exp_e));
        chk("rr_busy_no_ready", 32'(busy_rdy), 32'd0);
        chk("rr_rsp_stable", 32'(stab_bad), 32'd0);
    endtask

    initial begin
        int acc, rc, le, lr;
        logic [7:0] d;
        logic id, e;
        bit bad, rdybad;

        tbl[0] = '{0, 8'd12,  8'd5,   FUN_ADD, 8'd17};
        tbl[1] = '{0, 8'd12,  8'd5,   FUN_SUB, 8'd7};
        tbl[2] = '{1, 8'd6,   8'd7,   FUN_MUL, 8'd42};
        tbl[3] = '{1, 8'd9,   8'd3,   FUN_DIV, 8'd3};
        tbl[4] = '{0, 8'd200, 8'd100, FUN_ADD, 8'd44};
        tbl[5] = '{1, 8'd3,   8'd5,   FUN_SUB, 8'd254};
        tbl[6] = '{0, 8'd16,  8'd16,  FUN_MUL, 8'd0};
        tbl[7] = '{1, 8'd255, 8'd1,   FUN_ADD, 8'd0};

        // Reset state
        RST = 1'b0;
        repeat (3) tick();
        @(negedge CLK);
        chk("rst_outputs", {2'd0, ALU_A, ALU_B, ALU_FUN, ALU_EN, RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR}, 32'd0);
        tick();
        RST = 1'b1;
        last_g = 1;

        // Both requesters valid right out of reset: requester 0 first, then 1
        pend[0] = 1; opa[0] = 8'd12; opb[0] = 8'd5; opf[0] = FUN_SUB;
        pend[1] = 1; opa[1] = 8'd6;  opb[1] = 8'd7; opf[1] = FUN_MUL;
        serve_one(1'b0);
        serve_one(1'b0);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].rid, tbl[i].a, tbl[i].b, tbl[i].f, d, id, e, le, lr);
            chk($sformatf("tbl%0d_data", i), 32'(d), 32'(tbl[i].exp_d));
            chk($sformatf("tbl%0d_id", i), 32'(id), 32'(tbl[i].rid));
            chk($sformatf("tbl%0d_err", i), 32'(e), 32'd0);
            chk($sformatf("tbl%0d_en_lat", i), 32'(le), 32'd1);
            chk($sformatf("tbl%0d_en_cnt", i), 32'(en_cnt), 32'd1);
            chk($sformatf("tbl%0d_rsp_lat", i), 32'(lr), 32'd3);
        end

        // Response back-pressure with requester 1 waiting
        RSP_READY = 1'b0;
        drive_req(0, 1'b1, 8'd1, 8'd2, FUN_ADD);
        wait_ready(0, acc);
        drive_req(0, 1'b0, 8'd1, 8'd2, FUN_ADD);
        last_g = 0;
        drive_req(1, 1'b1, 8'd10, 8'd4, FUN_SUB);
        wait_rsp(rc);
        bad = 0; rdybad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!(RSP_VALID === 1'b1 && RSP_DATA === 8'd3 && RSP_ID === 1'b0 && RSP_ERR === 1'b0)) bad = 1;
            if (REQ0_READY === 1'b1 || REQ1_READY === 1'b1) rdybad = 1;
            tick();
            @(negedge CLK);
        end
        chk("bp_rsp_hold", 32'(bad), 32'd0);
        chk("bp_no_ready", 32'(rdybad), 32'd0);
        RSP_READY = 1'b1;
        tick();
        @(negedge CLK);
        chk("bp_release_ready1", 32'(REQ1_READY), 32'd1);
        tick();
        drive_req(1, 1'b0, 8'd10, 8'd4, FUN_SUB);
        last_g = 1;
        wait_rsp(rc);
        chk("bp_second_data", 32'(RSP_DATA), 32'd6);
        chk("bp_second_id", 32'(RSP_ID), 32'd1);
        tick();

        // Missing OUT_VALID -> timeout error, then a late OUT_VALID in IDLE
        suppress = 1'b1;
        drive_req(0, 1'b1, 8'd4, 8'd4, FUN_ADD);
        wait_ready(0, acc);
        drive_req(0, 1'b0, 8'd4, 8'd4, FUN_ADD);
        last_g = 0;
        wait_rsp(rc);
        chk("to_latency", 32'(rc - acc), 32'd6);
        chk("to_err", 32'(RSP_ERR), 32'd1);
        chk("to_data", 32'(RSP_DATA), 32'd0);
        chk("to_id", 32'(RSP_ID), 32'd0);
        tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        @(negedge CLK);
        chk("late_valid_ignored_a", 32'(RSP_VALID), 32'd0);
        tick();
        @(negedge CLK);
        chk("late_valid_ignored_b", 32'(RSP_VALID), 32'd0);
        tick();

        // Reset while in WAIT abandons the operation
        drive_req(0, 1'b1, 8'd7, 8'd7, FUN_ADD);
        wait_ready(0, acc);
        drive_req(0, 1'b0, 8'd7, 8'd7, FUN_ADD);
        tick();
        @(negedge CLK);
        chk("wait_alu_a", 32'(ALU_A), 32'd7);
        RST = 1'b0;
        tick();
        RST = 1'b1;
        last_g = 1;
        @(negedge CLK);
        chk("midrst_outputs", {2'd0, ALU_A, ALU_B, ALU_FUN, ALU_EN, RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR}, 32'd0);
        tick();
        suppress = 1'b0;
        do_op(1, 8'd9, 8'd3, FUN_DIV, d, id, e, le, lr);
        chk("postrst_data", 32'(d), 32'd3);
        chk("postrst_id", 32'(id), 32'd1);
        chk("postrst_err", 32'(e), 32'd0);

        // Divide by zero
        do_op(0, 8'd9, 8'd0, FUN_DIV, d, id, e, le, lr);
`ifdef DIV0_GUARD_EN
        chk("div0_en_cnt", 32'(en_cnt), 32'd0);
        chk("div0_err", 32'(e), 32'd1);
        chk("div0_data", 32'(d), 32'd0);
        chk("div0_rsp_lat", 32'(lr), 32'd2);
`else
        chk("div0_en_cnt", 32'(en_cnt), 32'd1);
        chk("div0_err", 32'(e), 32'd0);
        chk("div0_data", 32'(d), 32'hFF);
        chk("div0_rsp_lat", 32'(lr), 32'd3);
`endif

        // Randomized traffic with random response back-pressure
        pend[0] = 0;
        pend[1] = 0;
        for (int it = 0; it < 60; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r] = 1;
                    opa[r] = 8'($urandom);
                    opb[r] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
                    opf[r] = 2'($urandom);
                end
            end
            if (pend[0] || pend[1]) serve_one(1'b1);
        end
        while (pend[0] || pend[1]) serve_one(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
